temperature_table_builder: RTL
==============================

Name: temperature_table_builder

Overview:
- Writer side of the temperature-conversion lookup memory. On `start`, it computes every table entry with incremental shift/add arithmetic; there is no multiplier or divider.
- It streams the entries, one write per cycle, into the 512x7 conversion RAM that the lookup path later reads with address {unit, temperature}.
- It sits between system control and the write port of the conversion RAM. It replaces static file preload, so the table can be rebuilt at runtime.

Parameters:
- OFFSET_F, 32: Fahrenheit offset used in both conversions.
- MAX_OUT, 127: saturation ceiling for written data. Must fit in 7 bits.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to (re)build the table; ignored while busy=1
- busy  out  1  high from the cycle after an accepted start until the last write completes
- done  out  1  one-cycle pulse, the cycle after the final accepted write
- wr_en  out  1  write request to the RAM
- wr_ready  in  1  RAM accepts the write when wr_en && wr_ready on a clk edge
- wr_addr  out  9  {unit, temperature[7:0]}
- wr_data  out  7  converted value

Behaviour:
- Reset (synchronous, active-high):
  - busy=0, done=0, wr_en=0, wr_addr=0, wr_data=0; FSM=IDLE; accumulators cleared.
  - Reset asserted mid-build aborts immediately on that edge. The RAM is left partially written and must be rebuilt.
- FSM states: IDLE, FILL_F2C, FILL_C2F, FINISH.
  - IDLE: start=1 -> FILL_F2C. On the next cycle: busy=1, wr_en=1, wr_addr=0x000.
  - FILL_F2C (unit=0): addresses 0..255, where temperature is in deg F. On the accepted write at address 255 -> FILL_C2F.
  - FILL_C2F (unit=1): addresses 256..511, where temperature is in deg C. On the accepted write at address 511 -> FINISH.
  - FINISH: wr_en=0, busy=0, done=1 for exactly one cycle -> IDLE.
  - start asserted in FINISH or any FILL state is ignored.
- Handshake:
  - A write completes only on an edge with wr_en && wr_ready.
  - While wr_ready=0, wr_en, wr_addr and wr_data hold stable and the accumulators do not advance.
  - With wr_ready tied high, the build takes exactly 512 wr_en cycles, and done occurs 513 cycles after the start edge.
- F->C entry, for address T:
  - Value = round-half-up((T-32)*5/9); 0 for T<32.
  - Implementation: quotient q, remainder r in 0..8. From T=32 onward, each step does r+=5; if r>=9 then r-=9, q+=1. Output q+(r>=5).
  - Maximum value is 124 (T=255), which fits without saturation.
- C->F entry, for address T:
  - Value = min(MAX_OUT, 32 + round-half-up(9T/5)).
  - Implementation: r in 0..4. Each step does r+=9, then subtract 5 up to twice, incrementing q each time. Output 32+q+(r>=3), saturated.
  - Saturation is sticky once reached; the internal q width must not wrap before T=255.
- Simultaneous events:
  - reset has priority over everything.
  - start in the same cycle as reset is ignored.
  - start on the same edge that done is high is ignored; done returns to IDLE first.

Test Plan:
- Reset, then start with wr_ready=1 -> first write {addr 0x000, data 0}. Check F->C entries 0x000..0x01F (T=0..31) = 0; 0x020=0, 0x032=10, 0x064=38, 0x0D4=100, 0x0FF=124. Expect exactly 512 writes with addresses strictly incrementing, then a one-cycle done and busy=0.
- C->F half, from the same build: addr 0x100=32, 0x10A=50, 0x125=99, 0x134=126, 0x135=127, 0x136 through 0x1FF all =127 (saturated).
- Random wr_ready deassertion, about 30% low -> addr and data held stable while stalled. Final RAM image identical to the no-stall run; done occurs the cycle after the 512th accepted write.
- Assert start again at write 100 -> ignored, no restart, exactly 512 writes. After done, start again -> a second full build producing an identical image.
- Assert reset while writing address 0x150 -> the next cycle shows busy=0, wr_en=0, wr_addr=0, done never pulses. A subsequent start performs a full 512-write build.
- reset and start high in the same cycle -> remains IDLE, no writes.

Source files
------------

// File: rtl/temperature_table_builder.sv
// Writer for the 512x7 temperature-conversion RAM: rebuilds every F->C and C->F entry
// with incremental shift/add arithmetic and streams them one write per accepted cycle.
module temperature_table_builder #(
    parameter int unsigned OFFSET_F = 32,
    parameter int unsigned MAX_OUT  = 127
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       wr_en,
    input  logic       wr_ready,
    output logic [8:0] wr_addr,
    output logic [6:0] wr_data
);

    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DATA_W = 7;
    localparam int unsigned FQ_W   = 7;
    localparam int unsigned CQ_W   = 9;
    localparam int unsigned SUM_W  = 10;

    localparam logic [7:0]        OFF_T   = 8'(OFFSET_F);
    localparam logic [SUM_W-1:0]  OFF_SUM = SUM_W'(OFFSET_F);
    localparam logic [SUM_W-1:0]  MAX_SUM = SUM_W'(MAX_OUT);
    localparam logic [DATA_W-1:0] MAX_VAL = DATA_W'(MAX_OUT);

    typedef enum logic [1:0] {IDLE, FILL_F2C, FILL_C2F, FINISH} state_t;

    state_t state, state_nxt;
    logic   busy_nxt, wr_en_nxt, done_nxt;

    logic [FQ_W-1:0]   fq, fq_n;
    logic [3:0]        fr, fr_n, fr_sum;
    logic [CQ_W-1:0]   cq, cq_n;
    logic [2:0]        cr, cr_n;
    logic [3:0]        cr_sum, cr_one;
    logic              c_inc1, c_inc2;
    logic              sat, sat_n;
    logic [SUM_W-1:0]  c_sum;
    logic [DATA_W-1:0] f_val, c_val, data_n;
    logic [ADDR_W-1:0] addr_n;
    logic              accept, start_acc, f_step;

    assign accept    = wr_en && wr_ready;
    assign start_acc = (state == IDLE) && start;

    // State register and registered control outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            wr_en <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
            wr_en <= wr_en_nxt;
            done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = FILL_F2C;
            FILL_F2C: if (accept && wr_addr == 9'h0FF) state_nxt = FILL_C2F;
            FILL_C2F: if (accept && wr_addr == 9'h1FF) state_nxt = FINISH;
            FINISH:   state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Control outputs follow the state being entered so they line up with it
    always_comb begin
        busy_nxt  = 1'b0;
        wr_en_nxt = 1'b0;
        done_nxt  = 1'b0;
        case (state_nxt)
            FILL_F2C, FILL_C2F: begin
                busy_nxt  = 1'b1;
                wr_en_nxt = 1'b1;
            end
            FINISH:  done_nxt = 1'b1;
            default: ;
        endcase
    end

    // F->C: 5*(T-32) = 9*fq + fr, stepped only once T has reached the offset
    always_comb begin
        f_step = !wr_addr[8] && (wr_addr[7:0] >= OFF_T);
        fr_sum = fr + 4'd5;
        fq_n   = fq;
        fr_n   = fr;
        if (f_step) begin
            if (fr_sum >= 4'd9) begin
                fr_n = fr_sum - 4'd9;
                fq_n = fq + FQ_W'(1);
            end else begin
                fr_n = fr_sum;
            end
        end
        f_val = fq_n + DATA_W'(fr_n >= 4'd5);
    end

    // C->F: 9*T = 5*cq + cr; cq is wide enough for T=255 so saturation never relies on wrap
    always_comb begin
        cr_sum = 4'(cr) + 4'd9;
        c_inc1 = cr_sum >= 4'd5;
        cr_one = c_inc1 ? cr_sum - 4'd5 : cr_sum;
        c_inc2 = cr_one >= 4'd5;
        cq_n   = cq;
        cr_n   = cr;
        if (wr_addr[8]) begin
            cr_n = 3'(c_inc2 ? cr_one - 4'd5 : cr_one);
            cq_n = cq + CQ_W'(c_inc1) + CQ_W'(c_inc2);
        end
        c_sum  = OFF_SUM + SUM_W'(cq_n) + SUM_W'(cr_n >= 3'd3);
        sat_n  = sat || (c_sum >= MAX_SUM);
        c_val  = sat_n ? MAX_VAL : DATA_W'(c_sum);
        addr_n = wr_addr + ADDR_W'(1);
        data_n = addr_n[8] ? c_val : f_val;
    end

    // Address/data and accumulators advance only on an accepted write
    always_ff @(posedge clk) begin
        if (reset || start_acc) begin
            wr_addr <= '0;
            wr_data <= '0;
            fq      <= '0;
            fr      <= '0;
            cq      <= '0;
            cr      <= '0;
            sat     <= 1'b0;
        end else if (accept) begin
            wr_addr <= addr_n;
            wr_data <= data_n;
            fq      <= fq_n;
            fr      <= fr_n;
            cq      <= cq_n;
            cr      <= cr_n;
            sat     <= sat_n;
        end
    end

endmodule
